mem_byte_access_unit: RTL and testbench
=======================================

# mem_byte_access_unit

Memory-stage responder that executes the load/store requests produced by the instruction decoder (MemWrite, 3-bit MemOp size code, unsigned-load flag) against a byte-wide data memory. It latches one request, serializes it into 1, 2 or 4 byte transfers, and returns the assembled load data with sign or zero extension. It asserts `busy` so the pipeline stalls for the duration of each access, and flags misaligned or invalid requests. It sits between the MEM pipeline stage and the data-memory port.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of request and memory bus

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present; sampled only in IDLE
- req_write  in  1  1 = store, 0 = load (MemWrite)
- req_op  in  3  size code: 001 = byte, 010 = halfword, 100 = word; any other value is invalid
- req_unsigned  in  1  1 = zero-extend load (LBU/LHU/LWU), 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- misalign  out  1  one-cycle pulse with done; request rejected
- rdata  out  32  last completed load result
- mem_en  out  1  byte transfer request
- mem_we  out  1  byte write enable
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  read byte, valid when mem_ready = 1
- mem_ready  in  1  current byte completes at this edge

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE + req_valid: latch all request fields and set byte count N (1, 2 or 4) and index k = 0.
  - Invalid req_op, halfword with addr[0] ≠ 0, or word with addr[1:0] ≠ 0: go to DONE with the reject flag set. No bus activity.
  - Otherwise go to XFER.
- XFER: drive mem_en = 1, mem_we = req_write, mem_addr = addr + k (modulo 2^ADDR_W).
  - Ordering is big-endian: byte k carries data bits [8(N−1−k)+7 : 8(N−1−k)].
  - Stores: mem_wdata = that byte of req_wdata.
  - Loads: mem_rdata is shifted into the assembly register when mem_ready = 1.
  - On mem_ready = 1 with k = N−1: go to DONE. Otherwise increment k.
- DONE: done = 1 for one cycle; misalign = reject flag; then go to IDLE.
  - For a completed load, rdata is updated at the XFER→DONE edge.
  - Byte/halfword loads: sign-extend from bit 7/15 when req_unsigned = 0, zero-extend when req_unsigned = 1. Words are unextended.
  - Stores and rejected requests leave rdata unchanged.
- req_valid is ignored in XFER and DONE. Requests are never queued.

## Timing
- Reset (asynchronous, rst_n = 0): state IDLE; busy, done, misalign, mem_en, mem_we = 0; mem_addr, mem_wdata = 0; rdata = 0. An interrupted transfer is abandoned, not resumed.
- mem_en, mem_we, mem_addr and mem_wdata are registered. They stay stable while mem_en = 1 and mem_ready = 0.
- Zero wait states, request accepted at edge T:
  - XFER covers cycles T+1 … T+N, one byte per cycle.
  - done and rdata are valid in cycle T+N+1.
  - IDLE resumes at T+N+2.
- Each cycle with mem_ready = 0 in XFER adds one cycle of latency.
- Rejected request: done and misalign in cycle T+1; mem_en never asserts.
- busy rises the cycle after acceptance and falls the cycle after done.
- Back-to-back: the next request is accepted at the earliest in the first IDLE cycle after DONE.

## Test plan
- LW 0x10, memory bytes 12,34,56,78, mem_ready = 1 → mem_addr 0x10, 0x11, 0x12, 0x13 in T+1..T+4; done at T+5; rdata = 0x12345678.
- LB 0x21 with byte 0x80 → rdata = 0xFFFFFF80. LBU at the same address → rdata = 0x00000080.
- SH 0x40, wdata 0xDEADBEEF → writes 0x40←0xBE, 0x41←0xEF with mem_we = 1; done at T+3; rdata unchanged.
- LH 0x41, and separately req_op = 011 → no mem_en; done = misalign = 1 at T+1; rdata unchanged; busy high for one cycle only.
- LW with mem_ready held low for 2 cycles on byte 1 → mem_addr held at addr+1 for 3 cycles; done at T+7; data still correct.
- rst_n pulsed low after 2 bytes of an LW → all outputs 0 immediately; a new LB after release completes normally.

Source files
------------

// File: rtl/mem_byte_access_unit.sv
// Memory-stage load/store responder: serializes byte/half/word accesses onto a
// byte-wide memory port (big-endian) and returns sign/zero-extended load data.
module mem_byte_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_op,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic                uns_q, uns_d;
    logic                reject_q, reject_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          k_q, k_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [23:0]         asm_q, asm_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;

    logic                req_ok;
    logic [1:0]          req_last;
    logic [1:0]          k_next;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    pick_byte = w[7:0];
            2'd1:    pick_byte = w[15:8];
            2'd2:    pick_byte = w[23:16];
            default: pick_byte = w[31:24];
        endcase
    endfunction

    // last is N-1: 0 = byte, 1 = halfword, 3 = word
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] last,
                                           input logic uns);
        case (last)
            2'd0:    extend = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'd1:    extend = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    always_comb begin
        req_ok   = 1'b0;
        req_last = 2'd0;
        case (req_op)
            3'b001: begin req_ok = 1'b1;                   req_last = 2'd0; end
            3'b010: begin req_ok = ~req_addr[0];           req_last = 2'd1; end
            3'b100: begin req_ok = (req_addr[1:0] == 2'b00); req_last = 2'd3; end
            default: begin req_ok = 1'b0;                  req_last = 2'd0; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        uns_d       = uns_q;
        reject_d    = reject_q;
        last_d      = last_q;
        k_d         = k_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        rdata_d     = rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        k_next      = k_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    uns_d    = req_unsigned;
                    wdata_d  = req_wdata;
                    last_d   = req_last;
                    k_d      = 2'd0;
                    asm_d    = 24'd0;
                    reject_d = ~req_ok;
                    if (req_ok) begin
                        state_d     = XFER;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = pick_byte(req_wdata, req_last);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            XFER: begin
                if (mem_ready) begin
                    asm_d = {asm_q[15:0], mem_rdata};
                    if (k_q == last_q) begin
                        state_d  = DONE;
                        mem_en_d = 1'b0;
                        mem_we_d = 1'b0;
                        if (!write_q)
                            rdata_d = extend({asm_q, mem_rdata}, last_q, uns_q);
                    end else begin
                        // Bytes go out most-significant first.
                        k_d         = k_next;
                        mem_addr_d  = mem_addr_q + ADDR_W'(1);
                        mem_wdata_d = pick_byte(wdata_q, last_q - k_next);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            uns_q       <= 1'b0;
            reject_q    <= 1'b0;
            last_q      <= 2'd0;
            k_q         <= 2'd0;
            wdata_q     <= 32'd0;
            asm_q       <= 24'd0;
            rdata_q     <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            uns_q       <= uns_d;
            reject_q    <= reject_d;
            last_q      <= last_d;
            k_q         <= k_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign misalign  = (state_q == DONE) && reject_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_byte_access_unit.sv
// Bench for mem_byte_access_unit: vector table driven through a byte memory
// model, with a scoreboard queue matched against each done pulse.
module tb_mem_byte_access_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_write, req_unsigned;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              busy, done, misalign;
    logic [31:0]       rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    mem_byte_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_op(req_op),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .misalign(misalign), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        logic        write;
        logic [2:0]  op;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          exp_lat;
        logic [31:0] stall_addr;
        int          stall_n;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[13];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    task automatic run_vec(input vec_t v);
        int  n, k, stall_left;
        bit  seen_done;
        sb_t e;
        n = (v.op == 3'b100) ? 4 : (v.op == 3'b010) ? 2 : 1;
        sb_q.push_back('{v.exp_rdata, v.exp_mis, v.exp_lat});
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = v.write;
        req_op       = v.op;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        mem_ready    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        stall_left = v.stall_n;
        seen_done = 0;
        for (int c = 1; c <= 40 && !seen_done; c++) begin
            @(negedge clk);
            if (done) begin
                seen_done = 1;
                e = sb_q.pop_front();
                check("rdata", rdata, e.rdata);
                check("misalign", {31'd0, misalign}, {31'd0, e.mis});
                check("latency", 32'(c), 32'(e.lat));
                check("busy_in_done", {31'd0, busy}, 32'd1);
                check("bytes_moved", 32'(k), v.exp_mis ? 32'd0 : 32'(n));
            end else begin
                check("busy", {31'd0, busy}, 32'd1);
                check("mem_en", {31'd0, mem_en}, 32'd1);
                if (mem_en) begin
                    check("mem_addr", mem_addr, v.addr + 32'(k));
                    check("mem_we", {31'd0, mem_we}, {31'd0, v.write});
                    if (v.write && k < n)
                        check("mem_wdata", {24'd0, mem_wdata},
                              (v.wdata >> (8 * (n - 1 - k))) & 32'hFF);
                    if (mem_addr == v.stall_addr && stall_left > 0) begin
                        mem_ready = 1'b0;
                        stall_left--;
                    end else begin
                        mem_ready = 1'b1;
                        if (v.write) mem[mem_addr[7:0]] = mem_wdata;
                        k++;
                    end
                end
            end
        end
        if (!seen_done) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        // write, op, uns, addr, wdata, exp_rdata, exp_mis, exp_lat, stall_addr, stall_n
        vecs[0]  = '{1'b0, 3'b100, 1'b0, 32'h10, 32'h0,        32'h12345678, 1'b0, 5, 32'h0,  0};
        vecs[1]  = '{1'b0, 3'b001, 1'b0, 32'h21, 32'h0,        32'hFFFFFF80, 1'b0, 2, 32'h0,  0};
        vecs[2]  = '{1'b0, 3'b001, 1'b1, 32'h21, 32'h0,        32'h00000080, 1'b0, 2, 32'h0,  0};
        vecs[3]  = '{1'b1, 3'b010, 1'b0, 32'h40, 32'hDEADBEEF, 32'h00000080, 1'b0, 3, 32'h0,  0};
        vecs[4]  = '{1'b0, 3'b010, 1'b0, 32'h41, 32'h0,        32'h00000080, 1'b1, 1, 32'h0,  0};
        vecs[5]  = '{1'b0, 3'b011, 1'b0, 32'h50, 32'h0,        32'h00000080, 1'b1, 1, 32'h0,  0};
        vecs[6]  = '{1'b0, 3'b100, 1'b0, 32'h42, 32'h0,        32'h00000080, 1'b1, 1, 32'h0,  0};
        vecs[7]  = '{1'b0, 3'b010, 1'b0, 32'h40, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 32'h0,  0};
        vecs[8]  = '{1'b0, 3'b010, 1'b1, 32'h40, 32'h0,        32'h0000BEEF, 1'b0, 3, 32'h0,  0};
        vecs[9]  = '{1'b0, 3'b100, 1'b0, 32'h10, 32'h0,        32'h12345678, 1'b0, 7, 32'h11, 2};
        vecs[10] = '{1'b0, 3'b100, 1'b1, 32'h30, 32'h0,        32'h89ABCDEF, 1'b0, 5, 32'h0,  0};
        vecs[11] = '{1'b1, 3'b001, 1'b0, 32'hFF, 32'h123456A5, 32'h89ABCDEF, 1'b0, 2, 32'h0,  0};
        vecs[12] = '{1'b0, 3'b001, 1'b0, 32'hFF, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 32'h0,  0};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
        mem[8'h21] = 8'h80; mem[8'h22] = 8'h7F;
        mem[8'h30] = 8'h89; mem[8'h31] = 8'hAB; mem[8'h32] = 8'hCD; mem[8'h33] = 8'hEF;

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_op = 3'b000; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
            if (i == 3) begin
                check("sh_byte0", {24'd0, mem[8'h40]}, 32'hBE);
                check("sh_byte1", {24'd0, mem[8'h41]}, 32'hEF);
            end
        end
        check("sb_byte", {24'd0, mem[8'hFF]}, 32'hA5);

        // Abandon a word load after two bytes with an asynchronous reset.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_op = 3'b100; req_unsigned = 1'b0;
        req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done | misalign}, 32'd0);
        check("arst_mem_en", {31'd0, mem_en | mem_we}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("arst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[1]);
        run_vec('{1'b0, 3'b001, 1'b0, 32'h22, 32'h0, 32'h0000007F, 1'b0, 2, 32'h0, 0});

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
